// File: rtl/sc_riscv_pkg.sv
// Shared constants for the memory-mapped serial transmitter: register addresses,
// status word bit positions and the transmitter state encoding.
package sc_riscv_pkg;

  localparam logic [4:0] ADDR_DATA_DEF = 5'd30;
  localparam logic [4:0] ADDR_STAT_DEF = 5'd31;

  localparam int unsigned FIFO_DEPTH = 4;

  localparam int unsigned STAT_FULL   = 0;
  localparam int unsigned STAT_EMPTY  = 1;
  localparam int unsigned STAT_ACTIVE = 2;
  localparam int unsigned STAT_OVF    = 3;
  localparam int unsigned STAT_CNT    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// Four-entry byte FIFO feeding the serial transmitter. A push is accepted when full
// only if a pop happens in the same cycle.
module tx_fifo
  import sc_riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [2:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == 3'(FIFO_DEPTH));
  assign empty = (r_count == 3'd0);

endmodule

// File: rtl/serial_tx_block.sv
// Memory-mapped 8N1 serial transmitter: stores to the data address queue bytes,
// the status address reports FIFO/line state and clears the sticky overflow flag.
module serial_tx_block
  import sc_riscv_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [4:0]  ADDR_DATA    = ADDR_DATA_DEF,
  parameter logic [4:0]  ADDR_STAT    = ADDR_STAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  dir,
  input  logic [7:0]  D,
  input  logic        MemWrite,
  input  logic [31:0] ReadData,
  output logic [31:0] ReadDataOut,
  output logic        tx,
  output logic        busy
);

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  tx_state_e  r_state;
  logic [7:0] r_baud;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic       r_tx;
  logic       r_ovf;

  logic       w_push;
  logic       w_pop;
  logic       w_clr;
  logic       w_ovf_evt;
  logic       w_baud_done;
  logic [7:0] w_dout;
  logic [2:0] w_count;
  logic       w_full;
  logic       w_empty;
  logic       w_active;

  assign w_push      = MemWrite && (dir == ADDR_DATA);
  assign w_clr       = MemWrite && (dir == ADDR_STAT) && D[STAT_OVF];
  assign w_pop       = (r_state == StIdle) && !w_empty;
  assign w_ovf_evt   = w_push && w_full && !w_pop;
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign w_active    = (r_state != StIdle);

  tx_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (D),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // The baud counter restarts on every state change so each bit lasts CLKS_PER_BIT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= w_dout;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_state <= StStart;
          end
        end
        StStart: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= StData;
          end else begin
            r_baud <= r_baud + 8'd1;
          end
        end
        StData: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= StStop;
            end else begin
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 8'd1;
          end
        end
        StStop: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_state <= StIdle;
          end else begin
            r_baud <= r_baud + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // A dropped byte wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_evt) begin
      r_ovf <= 1'b1;
    end else if (w_clr) begin
      r_ovf <= 1'b0;
    end
  end

  always_comb begin
    ReadDataOut = ReadData;
    if (dir == ADDR_STAT) begin
      ReadDataOut                 = '0;
      ReadDataOut[STAT_CNT +: 3]  = w_count;
      ReadDataOut[STAT_OVF]       = r_ovf;
      ReadDataOut[STAT_ACTIVE]    = w_active;
      ReadDataOut[STAT_EMPTY]     = w_empty;
      ReadDataOut[STAT_FULL]      = w_full;
    end
  end

  assign tx   = r_tx;
  assign busy = !w_empty || w_active;

endmodule
